ram_sp_pipe: RTL and testbench

//  Parametrised single-port synchronous RAM with a valid/ready request port, per-byte write enables,
//  a selectable write mode, 1- or 2-cycle registered read latency and a post-reset zero-fill sweep.

---
 rtl/ram_sp_pipe.sv | 156 +++++++++++++++
 tb/tb_ram_sp_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_pipe.sv
// Single-port synchronous RAM behind a valid/ready request port, with byte enables,
// selectable write-response mode, 1- or 2-cycle read latency and a post-reset zero-fill sweep.
module ram_sp_pipe #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0,
  parameter int INIT_ENABLE  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    init_busy
);

  localparam int   DEPTH   = 1 << ADDR_WIDTH;
  localparam int   BE_W    = DATA_WIDTH / 8;
  localparam logic INIT_ON = (INIT_ENABLE != 0);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_w,
                                                         input logic [DATA_WIDTH-1:0] new_w,
                                                         input logic [BE_W-1:0]       be);
    logic [DATA_WIDTH-1:0] m;
    m = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

  // NO_CHANGE write responses carry the old word here; the output stage suppresses the update.
  function automatic logic [DATA_WIDTH-1:0] resp_word(input logic                  we,
                                                       input logic [DATA_WIDTH-1:0] old_w,
                                                       input logic [DATA_WIDTH-1:0] merged_w);
    if (we && (WRITE_MODE == 0)) return merged_w;
    return old_w;
  endfunction

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  req_ready_q;
  logic                  init_busy_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  vld_p0;
  logic                  hold_p0;
  logic [DATA_WIDTH-1:0] old_p0;
  logic [DATA_WIDTH-1:0] merged_p0;
  logic [DATA_WIDTH-1:0] data_p0;

  assign vld_p0    = req_valid & req_ready_q;
  assign old_p0    = mem[req_addr];
  assign merged_p0 = merge_bytes(old_p0, req_wdata, req_be);
  assign data_p0   = resp_word(req_we, old_p0, merged_p0);
  assign hold_p0   = req_we && (WRITE_MODE == 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT_ON ? ST_INIT : ST_RUN;
      ptr_q       <= '0;
      req_ready_q <= 1'b0;
      init_busy_q <= INIT_ON;
    end else begin
      case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + ADDR_WIDTH'(1);
          if (&ptr_q) begin
            state_q     <= ST_RUN;
            init_busy_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          req_ready_q <= 1'b1;
          init_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Array is never reset; the sweep and accepted writes are its only writers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) mem[ptr_q] <= '0;
      else if (vld_p0 && req_we) mem[req_addr] <= merged_p0;
    end
  end

  // ---- stage p0 -> p1 (optional registered array read) ----
  logic                  vld_s;
  logic                  hold_s;
  logic [DATA_WIDTH-1:0] data_s;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  vld_p1_q;
    logic                  hold_p1_q;
    logic [DATA_WIDTH-1:0] data_p1_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p1_q  <= 1'b0;
        hold_p1_q <= 1'b0;
        data_p1_q <= '0;
      end else begin
        vld_p1_q <= vld_p0;
        if (vld_p0) begin
          hold_p1_q <= hold_p0;
          data_p1_q <= data_p0;
        end
      end
    end

    assign vld_s  = vld_p1_q;
    assign hold_s = hold_p1_q;
    assign data_s = data_p1_q;
  end else begin : g_lat1
    assign vld_s  = vld_p0;
    assign hold_s = hold_p0;
    assign data_s = data_p0;
  end

  // ---- output register ----
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    if (vld_s && !hold_s) rsp_rdata_d = data_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= vld_s;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign init_busy = init_busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_sp_pipe.sv
// Directed bench: four RAM instances (WRITE_FIRST, READ_FIRST, NO_CHANGE at latency 1,
// WRITE_FIRST at latency 2) share one request stream; index 0..3 selects the instance.
module tb_ram_sp_pipe;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [3:0]  rdy;
  logic [3:0]  rv;
  logic [3:0]  bsy;
  logic [31:0] rd [4];

  int n_assert = 0;
  int n_fail   = 0;

  ram_sp_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .WRITE_MODE(0), .INIT_ENABLE(1)) u_wf (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .init_busy(bsy[0]));
  ram_sp_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .WRITE_MODE(1), .INIT_ENABLE(1)) u_rf (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .init_busy(bsy[1]));
  ram_sp_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .WRITE_MODE(2), .INIT_ENABLE(1)) u_nc (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .init_busy(bsy[2]));
  ram_sp_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2), .WRITE_MODE(0), .INIT_ENABLE(1)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[3]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[3]), .rsp_rdata(rd[3]), .init_busy(bsy[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts edges until all instances raise req_ready, flagging any response seen meanwhile.
  task automatic wait_ready(output int cnt, output logic any_vld);
    cnt     = 0;
    any_vld = 1'b0;
    while (rdy != 4'hF && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
      if (rdy != 4'hF && rv != 4'h0) any_vld = 1'b1;
    end
  endtask

  int   cnt;
  logic any_vld;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset_ready", {28'd0, rdy}, 32'h0);
    chk("reset_busy",  {28'd0, bsy}, 32'hF);
    chk("reset_valid", {28'd0, rv},  32'h0);
    chk("reset_rdata", rd[0],        32'h0);

    // Request held during the sweep must wait for the first RUN cycle.
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
    chk("init_busy_start", {28'd0, bsy}, 32'hF);
    wait_ready(cnt, any_vld);
    chk("init_cycles",      cnt,              32'd16);
    chk("init_no_rsp",      {31'd0, any_vld}, 32'h0);
    chk("init_busy_done",   {28'd0, bsy},     32'h0);
    tick();
    req_valid = 1'b0;
    chk("held_req_vld_l1",  {28'd0, rv},      32'h7);
    chk("held_req_data",    rd[0],            32'h0);
    tick();
    chk("held_req_vld_l2",  {28'd0, rv},      32'h8);

    // Zero-fill readback of all addresses, back to back.
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 4'(a), 32'h0, 4'h0);
      chk($sformatf("zero_vld_%0d", a),  {31'd0, rv[0]}, 32'h1);
      chk($sformatf("zero_data_%0d", a), rd[0],          32'h0);
    end
    tick();

    // Byte-enable merge and read-after-write.
    drive(1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
    chk("w1_wf", rd[0], 32'hDEADBEEF);
    chk("w1_rf", rd[1], 32'h00000000);
    chk("w1_nc", rd[2], 32'h00000000);
    drive(1'b1, 4'd3, 32'h000000AA, 4'h1);
    chk("w2_wf", rd[0], 32'hDEADBEAA);
    chk("w2_rf", rd[1], 32'hDEADBEEF);
    chk("w1_l2", rd[3], 32'hDEADBEEF);
    drive(1'b0, 4'd3, 32'h0, 4'h0);
    chk("raw_wf", rd[0], 32'hDEADBEAA);
    chk("raw_rf", rd[1], 32'hDEADBEAA);
    chk("raw_nc", rd[2], 32'hDEADBEAA);
    chk("w2_l2",  rd[3], 32'hDEADBEAA);
    tick();
    chk("raw_l2_vld",  {28'd0, rv}, 32'h8);
    chk("raw_l2_data", rd[3],       32'hDEADBEAA);

    // Write-mode behaviour on an overwrite.
    drive(1'b1, 4'd5, 32'h11111111, 4'hF);
    drive(1'b1, 4'd5, 32'h22222222, 4'hF);
    chk("wm_vld", {29'd0, rv[2:0]}, 32'h7);
    chk("wm_wf",  rd[0], 32'h22222222);
    chk("wm_rf",  rd[1], 32'h11111111);
    chk("wm_nc",  rd[2], 32'hDEADBEAA);
    drive(1'b1, 4'd5, 32'hFFFFFFFF, 4'h0);
    chk("be0_vld", {29'd0, rv[2:0]}, 32'h7);
    chk("be0_wf",  rd[0], 32'h22222222);
    drive(1'b0, 4'd5, 32'h0, 4'h0);
    chk("be0_rd",  rd[1], 32'h22222222);
    tick();
    tick();

    // Back-to-back writes then reads; latency-2 pulses start two cycles after the first accept.
    for (int a = 0; a < 8; a++) begin
      drive(1'b1, 4'(a), 32'h100 + a, 4'hF);
      chk($sformatf("fill_wf_%0d", a), rd[0], 32'h100 + a);
    end
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b0, 4'(i), 32'h0, 4'h0);
      else tick();
      if (i < 8) chk($sformatf("b2b_l1_%0d", i), rd[0], 32'h100 + i);
      if (i >= 1 && i <= 8) begin
        chk($sformatf("b2b_l2_vld_%0d", i),  {31'd0, rv[3]}, 32'h1);
        chk($sformatf("b2b_l2_data_%0d", i), rd[3],          32'h100 + i - 1);
      end else begin
        chk($sformatf("b2b_l2_idle_%0d", i), {31'd0, rv[3]}, 32'h0);
      end
    end

    // Asynchronous reset, then a reset in the middle of the sweep.
    rst = 1'b1;
    #1;
    chk("arst_rdata", rd[0],       32'h0);
    chk("arst_ready", {28'd0, rdy}, 32'h0);
    chk("arst_busy",  {28'd0, bsy}, 32'hF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (9) tick();
    chk("sweep9_busy", {28'd0, bsy}, 32'hF);
    rst = 1'b1;
    #1;
    chk("midrst_ready", {28'd0, rdy}, 32'h0);
    chk("midrst_busy",  {28'd0, bsy}, 32'hF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready(cnt, any_vld);
    chk("resweep_cycles", cnt, 32'd16);
    drive(1'b0, 4'd3, 32'h0, 4'h0);
    chk("resweep_vld",  {31'd0, rv[0]}, 32'h1);
    chk("resweep_zero", rd[0],          32'h0);
    drive(1'b0, 4'd7, 32'h0, 4'h0);
    chk("resweep_zero7", rd[1], 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
